// File: rtl/crossbar_8x8_write_arb_pkg.sv
// ============================================================================
//  Module      : crossbar_8x8_write_arb_pkg
//  Description : Shared request layout for the 8x8 LSU/CBG crossbars.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

// Extract request 'port' from a flattened request bus of req_w-bit entries.
`define XBAR_REQ_FIELD(vec, port, req_w) vec[(port)*(req_w) +: (req_w)]

package crossbar_8x8_write_arb_pkg;

    localparam int XBAR_N_PORT = 8;
    localparam int XBAR_SEL_W  = 3;
    localparam int XBAR_ADDR_W = 10;
    localparam int XBAR_DATA_W = 32;

    // Request layout, MSB to LSB: {sel, addr, data, wen}.
    localparam int XBAR_WEN_LSB  = 0;
    localparam int XBAR_DATA_LSB = 1;

    function automatic int xbar_req_w(input int sel_w, input int addr_w, input int data_w);
        return sel_w + addr_w + data_w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crossbar_8x8_write_arb_rr_arb_n.sv
// ============================================================================
//  Module      : rr_arb_n
//  Description : N-way round-robin arbiter; first requester at or after ptr.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb_n #(
    parameter int N_PORT = 8,
    parameter int SEL_W  = 3
) (
    input  logic [N_PORT-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [N_PORT-1:0] gnt,
    output logic [SEL_W-1:0]  idx
);

    logic             w_found;
    logic [SEL_W-1:0] w_cand;

    // Candidate index wraps naturally because N_PORT is a power of two.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int o = 0; o < N_PORT; o++) begin
            w_cand = ptr + SEL_W'(o);
            if (en && !w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/crossbar_8x8_write_arb.sv
// ============================================================================
//  Module      : crossbar_8x8_write_arb
//  Description : LSU-to-CBG write crossbar with per-bank round-robin arbitration
//                and a registered, ready-honouring output slot per bank.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module crossbar_8x8_write_arb
    import crossbar_8x8_write_arb_pkg::*;
#(
    parameter int N_PORT = XBAR_N_PORT,
    parameter int SEL_W  = XBAR_SEL_W,
    parameter int ADDR_W = XBAR_ADDR_W,
    parameter int DATA_W = XBAR_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_PORT*xbar_req_w(SEL_W, ADDR_W, DATA_W)-1:0] lsu_w_req,
    output logic [N_PORT-1:0]              lsu_w_gnt,
    input  logic [N_PORT-1:0]              cbg_w_rdy,
    output logic [N_PORT-1:0]              cbg_wen,
    output logic [N_PORT*ADDR_W-1:0]       cbg_addr,
    output logic [N_PORT*DATA_W-1:0]       cbg_data,
    output logic [N_PORT*SEL_W-1:0]        cbg_src,
    input  logic                           stat_clr,
    output logic [CNT_W-1:0]               conflict_cnt
);

    localparam int REQ_W    = xbar_req_w(SEL_W, ADDR_W, DATA_W);
    localparam int ADDR_LSB = XBAR_DATA_LSB + DATA_W;

    logic [N_PORT-1:0] w_wen;
    logic [SEL_W-1:0]  w_sel  [N_PORT];
    logic [ADDR_W-1:0] w_addr [N_PORT];
    logic [DATA_W-1:0] w_data [N_PORT];
    logic [N_PORT-1:0] w_bank_gnt [N_PORT];
    logic [N_PORT-1:0] w_lsu_gnt;
    logic              w_conflict;
    logic [CNT_W-1:0]  r_conflict_cnt;

    generate
        for (genvar i = 0; i < N_PORT; i++) begin : g_unpack
            logic [REQ_W-1:0] w_req;
            assign w_req     = `XBAR_REQ_FIELD(lsu_w_req, i, REQ_W);
            assign w_wen[i]  = w_req[XBAR_WEN_LSB];
            assign w_data[i] = w_req[XBAR_DATA_LSB +: DATA_W];
            assign w_addr[i] = w_req[ADDR_LSB +: ADDR_W];
            assign w_sel[i]  = w_req[REQ_W-1 -: SEL_W];
        end

        for (genvar k = 0; k < N_PORT; k++) begin : g_bank
            logic [N_PORT-1:0] w_req_vec;
            logic [N_PORT-1:0] w_gnt_vec;
            logic [SEL_W-1:0]  w_win;
            logic              w_free;
            logic              r_wen;
            logic [ADDR_W-1:0] r_addr;
            logic [DATA_W-1:0] r_data;
            logic [SEL_W-1:0]  r_src;
            logic [SEL_W-1:0]  r_ptr;

            always_comb begin
                w_req_vec = '0;
                for (int i = 0; i < N_PORT; i++) begin
                    w_req_vec[i] = w_wen[i] && (w_sel[i] == SEL_W'(k));
                end
            end

            // Consuming the slot and refilling it happen in the same cycle.
            assign w_free = !r_wen || cbg_w_rdy[k];

            rr_arb_n #(
                .N_PORT (N_PORT),
                .SEL_W  (SEL_W)
            ) u_arb (
                .req (w_req_vec),
                .ptr (r_ptr),
                .en  (w_free),
                .gnt (w_gnt_vec),
                .idx (w_win)
            );

            assign w_bank_gnt[k] = w_gnt_vec;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wen  <= 1'b0;
                    r_addr <= '0;
                    r_data <= '0;
                    r_src  <= '0;
                    r_ptr  <= '0;
                end else if (|w_gnt_vec) begin
                    r_wen  <= 1'b1;
                    r_addr <= w_addr[w_win];
                    r_data <= w_data[w_win];
                    r_src  <= w_win;
                    r_ptr  <= w_win + SEL_W'(1);
                end else if (cbg_w_rdy[k]) begin
                    r_wen  <= 1'b0;
                end
            end

            assign cbg_wen[k]                     = r_wen;
            assign cbg_addr[k*ADDR_W +: ADDR_W]   = r_addr;
            assign cbg_data[k*DATA_W +: DATA_W]   = r_data;
            assign cbg_src[k*SEL_W +: SEL_W]      = r_src;
        end
    endgenerate

    always_comb begin
        w_lsu_gnt = '0;
        for (int k = 0; k < N_PORT; k++) begin
            w_lsu_gnt = w_lsu_gnt | w_bank_gnt[k];
        end
    end

    assign lsu_w_gnt  = w_lsu_gnt & {N_PORT{rst_n}};
    assign w_conflict = |(w_wen & ~w_lsu_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (stat_clr) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_crossbar_8x8_write_arb.sv
// ============================================================================
//  Module      : tb_crossbar_8x8_write_arb
//  Description : Scoreboard bench for crossbar_8x8_write_arb (CNT_W=4 build).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crossbar_8x8_write_arb;

    localparam int N  = 8;
    localparam int SW = 3;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int RW = SW + AW + DW + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*RW-1:0] lsu_w_req = '0;
    logic [N-1:0]    lsu_w_gnt;
    logic [N-1:0]    cbg_w_rdy = '0;
    logic [N-1:0]    cbg_wen;
    logic [N*AW-1:0] cbg_addr;
    logic [N*DW-1:0] cbg_data;
    logic [N*SW-1:0] cbg_src;
    logic            stat_clr = 1'b0;
    logic [CW-1:0]   conflict_cnt;

    always #5 clk = ~clk;

    crossbar_8x8_write_arb #(
        .N_PORT (N), .SEL_W (SW), .ADDR_W (AW), .DATA_W (DW), .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu_w_req    (lsu_w_req),
        .lsu_w_gnt    (lsu_w_gnt),
        .cbg_w_rdy    (cbg_w_rdy),
        .cbg_wen      (cbg_wen),
        .cbg_addr     (cbg_addr),
        .cbg_data     (cbg_data),
        .cbg_src      (cbg_src),
        .stat_clr     (stat_clr),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } wr_t;

    // LSU-side request state: an LSU holds its request until granted.
    bit          req_v    [N];
    logic [SW-1:0] req_sel  [N];
    logic [AW-1:0] req_addr [N];
    logic [DW-1:0] req_data [N];
    logic [SW-1:0] junk_sel [N];

    // Reference model of the banks.
    int  m_ptr [N];
    bit  m_occ [N];
    int  m_cnt;
    wr_t exp_q [N][$];

    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int sel, input int addr, input logic [DW-1:0] data);
        req_v[i]    = 1'b1;
        req_sel[i]  = SW'(sel);
        req_addr[i] = AW'(addr);
        req_data[i] = data;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (req_v[i])
                lsu_w_req[i*RW +: RW] = {req_sel[i], req_addr[i], req_data[i], 1'b1};
            else
                lsu_w_req[i*RW +: RW] = {junk_sel[i], AW'($urandom), DW'($urandom), 1'b0};
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_ptr[k] = 0;
            m_occ[k] = 1'b0;
            exp_q[k].delete();
        end
        m_cnt = 0;
    endtask

    // One clock: called just after a rising edge with rdy/stat_clr/requests set.
    task automatic run_cycle();
        logic [N-1:0] eg;
        int  win [N];
        int  bestd;
        int  d;
        bit  conf;
        apply_inputs();
        eg = '0;
        for (int k = 0; k < N; k++) begin
            win[k] = -1;
            if (!m_occ[k] || cbg_w_rdy[k]) begin
                bestd = N;
                for (int i = 0; i < N; i++) begin
                    if (req_v[i] && int'(req_sel[i]) == k) begin
                        d = (i - m_ptr[k] + N) % N;
                        if (d < bestd) begin
                            bestd  = d;
                            win[k] = i;
                        end
                    end
                end
                if (win[k] >= 0) eg[win[k]] = 1'b1;
            end
        end
        conf = 1'b0;
        for (int i = 0; i < N; i++) if (req_v[i] && !eg[i]) conf = 1'b1;

        @(negedge clk);
        chk("lsu_w_gnt", 64'(lsu_w_gnt), 64'(eg));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        #1;
        for (int k = 0; k < N; k++) begin
            if (win[k] >= 0) begin
                exp_q[k].push_back('{a: req_addr[win[k]], d: req_data[win[k]], s: SW'(win[k])});
                m_occ[k] = 1'b1;
                m_ptr[k] = (win[k] + 1) % N;
                req_v[win[k]] = 1'b0;
            end else if (cbg_w_rdy[k]) begin
                m_occ[k] = 1'b0;
            end
        end
        if (stat_clr)                 m_cnt = 0;
        else if (conf && m_cnt < 15)  m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) if (req_v[i] || exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        cbg_w_rdy = '1;
        stat_clr  = 1'b0;
        for (int c = 0; c < 60 && !all_idle(); c++) run_cycle();
        chk("drain_idle", 64'(all_idle()), 64'(1));
    endtask

    // Monitor: every presented slot must match the oldest expected write.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("cbg_wen[%0d]", k), 64'(cbg_wen[k]), 64'(exp_q[k].size() != 0));
                if (cbg_wen[k] && cbg_w_rdy[k] && exp_q[k].size() != 0) begin
                    wr_t e;
                    e = exp_q[k].pop_front();
                    chk($sformatf("cbg_addr[%0d]", k), 64'(cbg_addr[k*AW +: AW]), 64'(e.a));
                    chk($sformatf("cbg_data[%0d]", k), 64'(cbg_data[k*DW +: DW]), 64'(e.d));
                    chk($sformatf("cbg_src[%0d]", k),  64'(cbg_src[k*SW +: SW]),  64'(e.s));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_v[i]    = 1'b0;
            junk_sel[i] = SW'($urandom);
            req_sel[i]  = '0;
            req_addr[i] = '0;
            req_data[i] = '0;
        end
        model_reset();

        // Reset state, with a request already on the bus.
        set_req(1, 2, 'h55, 32'h1111_2222);
        apply_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(lsu_w_gnt), 64'(0));
        chk("rst_wen", 64'(cbg_wen), 64'(0));
        chk("rst_addr", 64'(cbg_addr[63:0]), 64'(0));
        chk("rst_data", 64'(cbg_data[63:0]), 64'(0));
        chk("rst_src", 64'(cbg_src), 64'(0));
        chk("rst_cnt", 64'(conflict_cnt), 64'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;
        drain();

        // Single write LSU3 -> bank5.
        cbg_w_rdy = '1;
        set_req(3, 5, 'h12, 32'hA5A5_A5A5);
        run_cycle();
        run_cycle();
        drain();

        // Three-way conflict on bank1.
        set_req(0, 1, 'h100, 32'h0000_0000);
        set_req(2, 1, 'h102, 32'h2222_2222);
        set_req(7, 1, 'h107, 32'h7777_7777);
        repeat (3) run_cycle();
        drain();

        // Bank4 blocked by a full slot with rdy low.
        cbg_w_rdy = '0;
        set_req(6, 4, 'h044, 32'hDEAD_0001);
        run_cycle();
        set_req(6, 4, 'h045, 32'hDEAD_0002);
        repeat (3) run_cycle();
        cbg_w_rdy = '1;
        run_cycle();
        drain();

        // All LSUs to distinct banks.
        for (int i = 0; i < N; i++) set_req(i, 7 - i, 'h200 + i, 32'hC0DE_0000 + i);
        run_cycle();
        drain();

        // Saturation of the conflict counter, then clear with a conflict present.
        for (int c = 0; c < 22; c++) begin
            for (int i = 0; i < N; i++) if (!req_v[i]) set_req(i, 0, $urandom, $urandom);
            stat_clr = (c == 20);
            run_cycle();
        end
        stat_clr = 1'b0;
        drain();

        // Reset mid-operation: move bank2's pointer, fill slots, leave requests pending.
        set_req(1, 2, 'h021, 32'h0000_0021);
        set_req(6, 2, 'h026, 32'h0000_0026);
        run_cycle();
        cbg_w_rdy = '0;
        run_cycle();
        set_req(0, 2, 'h020, 32'h0000_0020);
        set_req(5, 3, 'h035, 32'h0000_0035);
        run_cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_gnt", 64'(lsu_w_gnt), 64'(0));
        chk("midrst_wen", 64'(cbg_wen), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cbg_w_rdy = '1;
        run_cycle();
        chk("post_rst_lsu0_first", 64'(req_v[0]), 64'(0));
        drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                junk_sel[i] = SW'($urandom);
                if (!req_v[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 7),
                            $urandom, $urandom);
            end
            cbg_w_rdy = N'($urandom);
            stat_clr  = ($urandom_range(0, 15) == 0);
            run_cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
